mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single 128-bit main-memory port between the icache (line refill) and the dcache (line refill or dirty-line eviction).
- Grants one requester a whole cache-line burst of BEATS beats and issues the beat requests. It routes read beats back to the granted requester and streams dcache write beats to memory.
- Sits between icache/dcache miss logic and main memory; round-robin on contention.

Parameters:
AW, MEM_ADDR_BUS (12), memory word address width (128-bit words)
DW, MEM_DATA_BUS (128), memory data beat width
BEATS, MEM_TRANSFERS_PER_CL (4), beats per cache line; power of 2, checked with is_pow2 at elaboration

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ic_req_valid  in  1  icache line-read request
ic_req_ready  out  1  icache request accepted (grant)
ic_req_addr  in  AW  line address; low log2(BEATS) bits ignored
ic_rsp_valid  out  1  icache read beat valid
ic_rsp_last  out  1  final beat of icache line
dc_req_valid  in  1  dcache line request
dc_req_ready  out  1  dcache request accepted (grant)
dc_req_addr  in  AW  line address; low log2(BEATS) bits ignored
dc_req_rtype  in  1  dmem_rtype_t: DMEM_READ refill, DMEM_WRITE evict
dc_wdata_valid  in  1  eviction beat valid
dc_wdata_ready  out  1  eviction beat accepted
dc_wdata  in  DW  eviction beat data
dc_rsp_valid  out  1  dcache read beat valid
dc_rsp_last  out  1  final beat of dcache line
rsp_data  out  DW  read beat data, shared by both requesters; qualified by *_rsp_valid
mem_req_valid  out  1  beat request to memory
mem_req_ready  in  1  memory accepts beat request
mem_req_addr  out  AW  beat word address
mem_req_we  out  1  1 = write beat
mem_wdata  out  DW  write beat data
mem_rsp_valid  in  1  read beat return; in order, latency >= 1
mem_rsp_data  in  DW  read beat data

Behaviour:
- Reset (async, rst_n=0): state ARB_IDLE, counters 0, last_grant=DC so the icache wins the first tie. All valid/ready/last outputs are 0; rsp_data and mem_wdata are don't-care; mem_req_addr=0.
- States (mem_arb_state_t, 2 bits):
  - ARB_IDLE
  - ARB_IC_RD
  - ARB_DC_RD
  - ARB_DC_WR
- ARB_IDLE, grant:
  - *_req_ready is combinational, asserted only in IDLE, for at most one requester.
  - Only one valid requester: it is granted.
  - Both valid: the requester other than last_grant is granted.
  - On valid&ready: capture the base address with its low bits cleared, update last_grant, and move to the matching state next cycle.
  - Dropping valid before ready is legal; no grant is made.
- Read states:
  - mem_req_valid=1 while issue_cnt<BEATS; mem_req_addr = base | issue_cnt; mem_req_we=0.
  - issue_cnt increments on mem_req_valid&mem_req_ready.
  - Up to BEATS beats may be outstanding; the block issues without waiting for responses.
  - Each mem_rsp_valid is forwarded combinationally: *_rsp_valid=1 to the granted requester only, rsp_data=mem_rsp_data. resp_cnt increments.
  - *_rsp_last=1 with the beat where resp_cnt==BEATS-1. The state returns to IDLE on the next cycle.
- ARB_DC_WR:
  - mem_req_valid = dc_wdata_valid while issue_cnt<BEATS; mem_req_we=1; mem_wdata=dc_wdata.
  - dc_wdata_ready = mem_req_ready while issue_cnt<BEATS.
  - A beat transfers on dc_wdata_valid&mem_req_ready.
  - The state returns to IDLE the cycle after the BEATS-th beat is accepted. Writes have no response.
- Minimum turnaround: one IDLE cycle between bursts. No grant is made in the cycle the last beat completes.
- Response beats arriving while the response count is already complete, or in IDLE, are dropped. This is a protocol error and is flagged by an assertion.
- Reset mid-burst: the burst is abandoned immediately and no further rsp_valid is produced. Requesters and memory are reset by the same rst_n.
- Counters are log2(BEATS)+1 bits wide and never wrap. Address low bits come from issue_cnt[log2(BEATS)-1:0]; upper bits come from the captured base.

Decomposition:
- Shared package: mem_arb_state_t enum and a mem_arb_grant_t enum {GNT_IC, GNT_DC}.
- Reuse dmem_rtype_t, MEM_ADDR_BUS, MEM_DATA_BUS and MEM_TRANSFERS_PER_CL.
- No sub-module: a single FSM with issue and response counters.

Test Plan:
- IC read alone, base 0x123, mem_req_ready=1, 2-cycle memory latency -> mem_req_addr 0x120..0x123 in consecutive cycles; 4 ic_rsp_valid beats with the data unchanged; ic_rsp_last on the 4th beat; IDLE follows.
- Both request in the same cycle right after reset -> IC granted first. After IC completes, DC is granted; on the next tie, IC is granted again (alternation).
- DC evict, base 0x040, dc_wdata_valid toggling 1/0 and mem_req_ready stalled 2 cycles on beat 2 -> exactly 4 write beats at 0x040..0x043 with matching data; no rsp_valid.
- DC read with mem_req_ready=0 for 3 cycles, then 1 -> no beat is lost or duplicated; dc_rsp_last=1 only on the 4th beat; ic_rsp_valid stays 0 throughout.
- rst_n asserted after 2 of 4 read beats -> outputs are 0 immediately (async). After release, a stray mem_rsp_valid produces no rsp_valid, and a new IC request is served normally.
- ic_req_valid pulsed for 1 cycle while a DC burst is active -> no IC grant, because ic_req_ready stays 0 outside IDLE.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and sizing for the main-memory arbiter between icache and dcache.
// Holds the memory bus widths, request type, FSM state and grant encodings.
package mem_arbiter_pkg;

    localparam int unsigned MEM_ADDR_BUS         = 12;
    localparam int unsigned MEM_DATA_BUS         = 128;
    localparam int unsigned MEM_TRANSFERS_PER_CL = 4;

    typedef enum logic {
        DMEM_READ  = 1'b0,
        DMEM_WRITE = 1'b1
    } dmem_rtype_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_IC_RD = 2'd1,
        ARB_DC_RD = 2'd2,
        ARB_DC_WR = 2'd3
    } mem_arb_state_t;

    typedef enum logic {
        GNT_IC = 1'b0,
        GNT_DC = 1'b1
    } mem_arb_grant_t;

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Grants the shared memory port to icache or dcache for a full cache-line burst,
// issues the beat requests and steers read beats back to the granted requester.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned AW    = MEM_ADDR_BUS,
    parameter int unsigned DW    = MEM_DATA_BUS,
    parameter int unsigned BEATS = MEM_TRANSFERS_PER_CL
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ic_req_valid,
    output logic              ic_req_ready,
    input  logic [AW-1:0]     ic_req_addr,
    output logic              ic_rsp_valid,
    output logic              ic_rsp_last,
    input  logic              dc_req_valid,
    output logic              dc_req_ready,
    input  logic [AW-1:0]     dc_req_addr,
    input  dmem_rtype_t       dc_req_rtype,
    input  logic              dc_wdata_valid,
    output logic              dc_wdata_ready,
    input  logic [DW-1:0]     dc_wdata,
    output logic              dc_rsp_valid,
    output logic              dc_rsp_last,
    output logic [DW-1:0]     rsp_data,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [AW-1:0]     mem_req_addr,
    output logic              mem_req_we,
    output logic [DW-1:0]     mem_wdata,
    input  logic              mem_rsp_valid,
    input  logic [DW-1:0]     mem_rsp_data
);

    localparam int unsigned LB = $clog2(BEATS);
    localparam int unsigned CW = LB + 1;
    localparam int unsigned BW = AW - LB;
    localparam logic [CW-1:0] CNT_FULL = CW'(BEATS);
    localparam logic [CW-1:0] CNT_LAST = CW'(BEATS - 1);

    generate
        if (!is_pow2(BEATS) || (BEATS < 2)) begin : g_bad_beats
            $error("mem_arbiter: BEATS must be a power of two and at least 2");
        end
    endgenerate

    mem_arb_state_t state_q, state_d;
    mem_arb_grant_t last_q, last_d;
    logic [CW-1:0]  issue_q, issue_d;
    logic [CW-1:0]  resp_q, resp_d;
    logic [BW-1:0]  base_q, base_d;

    logic           gnt_ic;
    logic           gnt_dc;
    logic           issuing;
    logic           resp_open;
    logic [AW-1:0]  beat_addr;
    logic           unused_addr_bits;

    // Line base comes from the captured request; the beat index fills the low bits.
    assign unused_addr_bits = ^{ic_req_addr[LB-1:0], dc_req_addr[LB-1:0]};

    // Round-robin: on a tie the requester that was not served last wins.
    assign gnt_ic    = ic_req_valid && (!dc_req_valid || (last_q == GNT_DC));
    assign gnt_dc    = dc_req_valid && !gnt_ic;
    assign issuing   = issue_q < CNT_FULL;
    assign resp_open = resp_q < CNT_FULL;
    assign beat_addr = {base_q, issue_q[LB-1:0]};

    assign rsp_data  = mem_rsp_data;
    assign mem_wdata = dc_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            last_q  <= GNT_DC;
            issue_q <= '0;
            resp_q  <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            issue_q <= issue_d;
            resp_q  <= resp_d;
            base_q  <= base_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        last_d         = last_q;
        issue_d        = issue_q;
        resp_d         = resp_q;
        base_d         = base_q;
        ic_req_ready   = 1'b0;
        dc_req_ready   = 1'b0;
        ic_rsp_valid   = 1'b0;
        ic_rsp_last    = 1'b0;
        dc_rsp_valid   = 1'b0;
        dc_rsp_last    = 1'b0;
        dc_wdata_ready = 1'b0;
        mem_req_valid  = 1'b0;
        mem_req_addr   = '0;
        mem_req_we     = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                issue_d = '0;
                resp_d  = '0;
                if (gnt_ic) begin
                    ic_req_ready = 1'b1;
                    base_d       = ic_req_addr[AW-1:LB];
                    last_d       = GNT_IC;
                    state_d      = ARB_IC_RD;
                end else if (gnt_dc) begin
                    dc_req_ready = 1'b1;
                    base_d       = dc_req_addr[AW-1:LB];
                    last_d       = GNT_DC;
                    state_d      = (dc_req_rtype == DMEM_WRITE) ? ARB_DC_WR : ARB_DC_RD;
                end
            end

            // Beats are issued back to back; responses are counted independently.
            ARB_IC_RD, ARB_DC_RD: begin
                mem_req_valid = issuing;
                mem_req_addr  = beat_addr;
                if (issuing && mem_req_ready) begin
                    issue_d = issue_q + CW'(1);
                end
                if (mem_rsp_valid && resp_open) begin
                    resp_d = resp_q + CW'(1);
                    if (state_q == ARB_IC_RD) begin
                        ic_rsp_valid = 1'b1;
                        ic_rsp_last  = (resp_q == CNT_LAST);
                    end else begin
                        dc_rsp_valid = 1'b1;
                        dc_rsp_last  = (resp_q == CNT_LAST);
                    end
                    if (resp_q == CNT_LAST) begin
                        state_d = ARB_IDLE;
                    end
                end
            end

            ARB_DC_WR: begin
                mem_req_valid  = dc_wdata_valid && issuing;
                mem_req_addr   = beat_addr;
                mem_req_we     = 1'b1;
                dc_wdata_ready = mem_req_ready && issuing;
                if (dc_wdata_valid && mem_req_ready && issuing) begin
                    issue_d = issue_q + CW'(1);
                    if (issue_q == CNT_LAST) begin
                        state_d = ARB_IDLE;
                    end
                end
            end

            default: state_d = ARB_IDLE;
        endcase
    end

    // A read beat with no open read burst is a memory-side protocol error; it is dropped.
    a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
        mem_rsp_valid |-> (((state_q == ARB_IC_RD) || (state_q == ARB_DC_RD)) && resp_open))
        else $warning("mem_arbiter: read beat outside an open read burst dropped");

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a 2-cycle in-order memory model, a negedge monitor
// logging handshakes, and hand-computed expectations per scenario.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int unsigned AW = MEM_ADDR_BUS;
    localparam int unsigned DW = MEM_DATA_BUS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ic_req_valid = 1'b0;
    logic          ic_req_ready;
    logic [AW-1:0] ic_req_addr = '0;
    logic          ic_rsp_valid;
    logic          ic_rsp_last;
    logic          dc_req_valid = 1'b0;
    logic          dc_req_ready;
    logic [AW-1:0] dc_req_addr = '0;
    dmem_rtype_t   dc_req_rtype = DMEM_READ;
    logic          dc_wdata_valid = 1'b0;
    logic          dc_wdata_ready;
    logic [DW-1:0] dc_wdata = '0;
    logic          dc_rsp_valid;
    logic          dc_rsp_last;
    logic [DW-1:0] rsp_data;
    logic          mem_req_valid;
    logic          mem_req_ready = 1'b1;
    logic [AW-1:0] mem_req_addr;
    logic          mem_req_we;
    logic [DW-1:0] mem_wdata;
    logic          mem_rsp_valid;
    logic [DW-1:0] mem_rsp_data;

    mem_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ic_req_valid   (ic_req_valid),
        .ic_req_ready   (ic_req_ready),
        .ic_req_addr    (ic_req_addr),
        .ic_rsp_valid   (ic_rsp_valid),
        .ic_rsp_last    (ic_rsp_last),
        .dc_req_valid   (dc_req_valid),
        .dc_req_ready   (dc_req_ready),
        .dc_req_addr    (dc_req_addr),
        .dc_req_rtype   (dc_req_rtype),
        .dc_wdata_valid (dc_wdata_valid),
        .dc_wdata_ready (dc_wdata_ready),
        .dc_wdata       (dc_wdata),
        .dc_rsp_valid   (dc_rsp_valid),
        .dc_rsp_last    (dc_rsp_last),
        .rsp_data       (rsp_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_we     (mem_req_we),
        .mem_wdata      (mem_wdata),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] beat_data(input logic [AW-1:0] a);
        return {8{4'hD, a}};
    endfunction

    function automatic logic [DW-1:0] wr_pat(input int i);
        return {4{32'hC0DE_0000 | 32'(i)}};
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory model: in-order read returns, two cycles after the accepting edge.
    logic          p1_v, p2_v;
    logic [AW-1:0] p1_a, p2_a;
    logic          stray = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_v <= 1'b0;
            p2_v <= 1'b0;
            p1_a <= '0;
            p2_a <= '0;
        end else begin
            p1_v <= mem_req_valid && mem_req_ready && !mem_req_we;
            p1_a <= mem_req_addr;
            p2_v <= p1_v;
            p2_a <= p1_a;
        end
    end

    assign mem_rsp_valid = p2_v || stray;
    assign mem_rsp_data  = stray ? {DW{1'b1}} : beat_data(p2_a);

    // Monitor: inputs only change just after posedge, so mid-cycle values are what the edge sees.
    logic [AW-1:0] wa[$];
    bit            wwe[$];
    logic [DW-1:0] wd[$];
    int            wcyc[$];
    logic [DW-1:0] icd[$], dcd[$];
    bit            icl[$], dcl[$];
    bit            gnt[$];
    int            gcyc[$];
    int            ic_last_cyc = -1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_req_valid && mem_req_ready) begin
                wa.push_back(mem_req_addr);
                wwe.push_back(mem_req_we);
                wd.push_back(mem_wdata);
                wcyc.push_back(cyc);
            end
            if (ic_rsp_valid) begin
                icd.push_back(rsp_data);
                icl.push_back(ic_rsp_last);
                if (ic_rsp_last) ic_last_cyc = cyc;
            end
            if (dc_rsp_valid) begin
                dcd.push_back(rsp_data);
                dcl.push_back(dc_rsp_last);
            end
            if (ic_req_valid && ic_req_ready) begin
                gnt.push_back(1'b0);
                gcyc.push_back(cyc);
            end
            if (dc_req_valid && dc_req_ready) begin
                gnt.push_back(1'b1);
                gcyc.push_back(cyc);
            end
        end
    end

    task automatic clear_log();
        wa.delete(); wwe.delete(); wd.delete(); wcyc.delete();
        icd.delete(); dcd.delete(); icl.delete(); dcl.delete();
        gnt.delete(); gcyc.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        ic_req_valid = 1'b0; dc_req_valid = 1'b0; dc_wdata_valid = 1'b0;
        mem_req_ready = 1'b1; stray = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    // Raise a request, wait (bounded) for the grant, drop valid after the handshake edge.
    task automatic do_req(input string tag, input bit is_dc, input logic [AW-1:0] a, input dmem_rtype_t rt);
        logic rdy;
        tick();
        if (is_dc) begin
            dc_req_valid = 1'b1; dc_req_addr = a; dc_req_rtype = rt;
        end else begin
            ic_req_valid = 1'b1; ic_req_addr = a;
        end
        #1;
        rdy = is_dc ? dc_req_ready : ic_req_ready;
        for (int k = 0; k < 40 && !rdy; k++) begin
            tick();
            rdy = is_dc ? dc_req_ready : ic_req_ready;
        end
        check_eq({tag, "_grant"}, 128'(rdy), 128'(1));
        tick();
        ic_req_valid = 1'b0;
        dc_req_valid = 1'b0;
    endtask

    task automatic check_read_burst(input string tag, input bit is_dc, input logic [AW-1:0] base);
        logic [DW-1:0] d[$];
        bit            l[$];
        int            other;
        if (is_dc) begin d = dcd; l = dcl; other = icd.size(); end
        else       begin d = icd; l = icl; other = dcd.size(); end
        check_eq({tag, "_nreq"}, 128'(wa.size()), 128'(4));
        for (int i = 0; i < wa.size(); i++) begin
            check_eq($sformatf("%s_addr%0d", tag, i), 128'(wa[i]), 128'(base + AW'(i)));
            check_eq($sformatf("%s_we%0d", tag, i), 128'(wwe[i]), 128'(0));
        end
        check_eq({tag, "_nbeats"}, 128'(d.size()), 128'(4));
        for (int i = 0; i < d.size(); i++) begin
            check_eq($sformatf("%s_data%0d", tag, i), d[i], beat_data(base + AW'(i)));
            check_eq($sformatf("%s_last%0d", tag, i), 128'(l[i]), 128'(i == 3));
        end
        check_eq({tag, "_other_rsp"}, 128'(other), 128'(0));
    endtask

    int dc_gnt_expect_cyc;
    int stall;

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ic_ready", 128'(ic_req_ready), 128'(0));
        check_eq("rst_dc_ready", 128'(dc_req_ready), 128'(0));
        check_eq("rst_mem_valid", 128'(mem_req_valid), 128'(0));
        check_eq("rst_mem_addr", 128'(mem_req_addr), 128'(0));
        check_eq("rst_wdata_ready", 128'(dc_wdata_ready), 128'(0));
        check_eq("rst_rsp_valid", 128'({ic_rsp_valid, dc_rsp_valid, ic_rsp_last, dc_rsp_last}), 128'(0));
        rst_n = 1'b1;

        // IC read alone, base 0x123 -> beats 0x120..0x123 on consecutive cycles
        clear_log();
        do_req("ic1", 1'b0, 12'h123, DMEM_READ);
        repeat (12) tick();
        check_read_burst("ic1", 1'b0, 12'h120);
        for (int i = 1; i < wcyc.size(); i++)
            check_eq($sformatf("ic1_back2back%0d", i), 128'(wcyc[i] - wcyc[0]), 128'(i));
        check_eq("ic1_idle_after", 128'(mem_req_valid), 128'(0));

        // Tie right after reset: IC, then DC, then IC again
        do_reset();
        clear_log();
        tick();
        ic_req_valid = 1'b1; ic_req_addr = 12'h300;
        dc_req_valid = 1'b1; dc_req_addr = 12'h200; dc_req_rtype = DMEM_READ;
        #1;
        check_eq("tie1_ic_ready", 128'(ic_req_ready), 128'(1));
        check_eq("tie1_dc_ready", 128'(dc_req_ready), 128'(0));
        tick();
        ic_req_valid = 1'b0;
        check_eq("tie1_dc_wait", 128'(dc_req_ready), 128'(0));
        for (int k = 0; k < 30 && !dc_req_ready; k++) tick();
        check_eq("tie_dc_grant", 128'(dc_req_ready), 128'(1));
        dc_gnt_expect_cyc = ic_last_cyc + 1;
        tick();
        dc_req_valid = 1'b0;
        repeat (12) tick();
        ic_req_valid = 1'b1; ic_req_addr = 12'h304;
        dc_req_valid = 1'b1; dc_req_addr = 12'h208;
        #1;
        check_eq("tie2_ic_ready", 128'(ic_req_ready), 128'(1));
        check_eq("tie2_dc_ready", 128'(dc_req_ready), 128'(0));
        tick();
        ic_req_valid = 1'b0;
        dc_req_valid = 1'b0;
        repeat (12) tick();
        check_eq("tie_ngrants", 128'(gnt.size()), 128'(3));
        if (gnt.size() == 3) begin
            check_eq("tie_order", 128'({gnt[0], gnt[1], gnt[2]}), 128'(3'b010));
            check_eq("tie_turnaround", 128'(gcyc[1]), 128'(dc_gnt_expect_cyc));
        end
        check_eq("tie_nbeats", 128'(wa.size()), 128'(12));
        if (wa.size() == 12) begin
            check_eq("tie_addr_ic", 128'(wa[0]), 128'(12'h300));
            check_eq("tie_addr_dc", 128'(wa[4]), 128'(12'h200));
            check_eq("tie_addr_ic2", 128'(wa[8]), 128'(12'h304));
        end

        // DC evict 0x040 with toggling wdata_valid and a 2-cycle stall on beat 2
        clear_log();
        do_req("wr", 1'b1, 12'h041, DMEM_WRITE);
        stall = 0;
        for (int k = 0; k < 40 && wa.size() < 4; k++) begin
            dc_wdata = wr_pat(wa.size());
            dc_wdata_valid = (k % 2 == 0);
            mem_req_ready = !(wa.size() == 1 && stall < 2);
            if (wa.size() == 1 && stall < 2) stall++;
            tick();
        end
        mem_req_ready = 1'b1;
        dc_wdata_valid = 1'b1;
        #1;
        check_eq("wr_done_ready", 128'(dc_wdata_ready), 128'(0));
        repeat (3) tick();
        dc_wdata_valid = 1'b0;
        check_eq("wr_nbeats", 128'(wa.size()), 128'(4));
        for (int i = 0; i < wa.size(); i++) begin
            check_eq($sformatf("wr_addr%0d", i), 128'(wa[i]), 128'(12'h040 + AW'(i)));
            check_eq($sformatf("wr_we%0d", i), 128'(wwe[i]), 128'(1));
            check_eq($sformatf("wr_data%0d", i), wd[i], wr_pat(i));
        end
        check_eq("wr_no_rsp", 128'(icd.size() + dcd.size()), 128'(0));

        // DC read 0x3F5 with mem_req_ready low for 3 cycles
        clear_log();
        do_req("dcrd", 1'b1, 12'h3F5, DMEM_READ);
        mem_req_ready = 1'b0;
        repeat (3) tick();
        mem_req_ready = 1'b1;
        repeat (12) tick();
        check_read_burst("dcrd", 1'b1, 12'h3F4);

        // IC pulse during a DC burst is not granted
        clear_log();
        do_req("busy", 1'b1, 12'h100, DMEM_READ);
        ic_req_valid = 1'b1; ic_req_addr = 12'h3C0;
        #1;
        check_eq("busy_ic_ready", 128'(ic_req_ready), 128'(0));
        tick();
        ic_req_valid = 1'b0;
        repeat (12) tick();
        check_eq("busy_ngrants", 128'(gnt.size()), 128'(1));
        check_read_burst("busy", 1'b1, 12'h100);

        // Reset after 2 of 4 read beats, then stray response, then normal service
        clear_log();
        do_req("mid", 1'b0, 12'h080, DMEM_READ);
        for (int k = 0; k < 40 && icd.size() < 2; k++) tick();
        check_eq("mid_two_beats", 128'(icd.size()), 128'(2));
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_mem_valid", 128'(mem_req_valid), 128'(0));
        check_eq("mid_rst_rsp", 128'({ic_rsp_valid, ic_rsp_last, dc_rsp_valid}), 128'(0));
        repeat (2) tick();
        rst_n = 1'b1;
        clear_log();
        tick();
        stray = 1'b1;
        #1;
        check_eq("stray_rsp", 128'({ic_rsp_valid, dc_rsp_valid}), 128'(0));
        tick();
        stray = 1'b0;
        check_eq("stray_logged", 128'(icd.size() + dcd.size()), 128'(0));
        do_req("post", 1'b0, 12'h1C2, DMEM_READ);
        repeat (12) tick();
        check_read_burst("post", 1'b0, 12'h1C0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
